// File: rtl/memory_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memory_stage_pkg : shared widths and wait-state FSM encoding, rev 1.0       |
// +----------------------------------------------------------------------------+
package memory_stage_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

endpackage : memory_stage_pkg
`default_nettype wire

// File: rtl/memory_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memory_stage_if : EX/MEM inputs, MEM/WB outputs and stall, rev 1.0          |
// | MisalignW exists only when MISALIGN_TRAP_EN is defined                      |
// +----------------------------------------------------------------------------+
interface memory_stage_if;
  import memory_stage_pkg::*;

  logic                  RegWriteM;
  logic                  MemtoRegM;
  logic                  MemWriteM;
  logic [WORD_W-1:0]     ALUOutM;
  logic [WORD_W-1:0]     WriteDataM;
  logic [REG_ADDR_W-1:0] WriteRegM;
  logic                  StallM;
  logic                  RegWriteW;
  logic                  MemtoRegW;
  logic [WORD_W-1:0]     ReadDataW;
  logic [WORD_W-1:0]     ALUOutW;
  logic [REG_ADDR_W-1:0] WriteRegW;
`ifdef MISALIGN_TRAP_EN
  logic                  MisalignW;
`endif

  modport master (
    output RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM,
    input  StallM, RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW
`ifdef MISALIGN_TRAP_EN
    , input MisalignW
`endif
  );

  modport slave (
    input  RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM,
    output StallM, RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW
`ifdef MISALIGN_TRAP_EN
    , output MisalignW
`endif
  );

endinterface : memory_stage_if
`default_nettype wire

// File: rtl/memory_stage_data_memory.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_memory : DEPTH x 32 array, synchronous write, asynchronous read, rev 1.0 |
// +----------------------------------------------------------------------------+
module data_memory
  import memory_stage_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : data_memory
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memory_stage : MIPS MEM stage with wait-state FSM and MEM/WB register, rev 1.0 |
// | Optional MISALIGN_TRAP_EN: trap unaligned accesses via MisalignW             |
// +----------------------------------------------------------------------------+
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 0
) (
  input  logic          clock,
  input  logic          reset,
  memory_stage_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic              w_access;
  logic              w_misalign;
  logic              w_stall;
  logic              w_complete;
  logic              w_we;
  logic [AW-1:0]     w_index;
  logic [WORD_W-1:0] w_rdata;

  assign w_access = bus.MemWriteM | bus.MemtoRegM;
  assign w_index  = bus.ALUOutM[AW+1:2];

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = w_access & (bus.ALUOutM[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  generate
    if (LATENCY == 0) begin : g_single
      assign w_stall    = 1'b0;
      assign w_complete = 1'b1;
    end else begin : g_wait
      localparam int CW = $clog2(LATENCY + 1);

      mem_state_t    state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          stall_c, complete_c;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_c    = 1'b0;
        complete_c = 1'b0;
        case (state_q)
          IDLE: begin
            if (w_access) begin
              stall_c = 1'b1;
              state_d = BUSY;
              cnt_d   = CW'(LATENCY - 1);
            end else begin
              complete_c = 1'b1;
            end
          end
          BUSY: begin
            if (cnt_q != '0) begin
              stall_c = 1'b1;
              cnt_d   = cnt_q - CW'(1);
            end else begin
              complete_c = 1'b1;
              state_d    = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end

      // Held low while in reset so the hazard unit never sees a stale stall.
      assign w_stall    = stall_c & reset;
      assign w_complete = complete_c;
    end
  endgenerate

  assign w_we       = bus.MemWriteM & w_complete & ~w_misalign & reset;
  assign bus.StallM = w_stall;

  data_memory #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dmem (
    .clock   (clock),
    .we_i    (w_we),
    .waddr_i (w_index),
    .wdata_i (bus.WriteDataM),
    .raddr_i (w_index),
    .rdata_o (w_rdata)
  );

  logic                  regwrite_q, memtoreg_q, misalign_q;
  logic [WORD_W-1:0]     readdata_q, aluout_q;
  logic [REG_ADDR_W-1:0] writereg_q;

  // Bubbles clear only the control bits; data fields hold their last value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      misalign_q <= 1'b0;
      readdata_q <= '0;
      aluout_q   <= '0;
      writereg_q <= '0;
    end else if (w_complete) begin
      regwrite_q <= bus.RegWriteM & ~w_misalign;
      memtoreg_q <= bus.MemtoRegM;
      misalign_q <= w_misalign;
      readdata_q <= bus.MemtoRegM ? w_rdata : '0;
      aluout_q   <= bus.ALUOutM;
      writereg_q <= bus.WriteRegM;
    end else begin
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      misalign_q <= 1'b0;
    end
  end

  assign bus.RegWriteW = regwrite_q;
  assign bus.MemtoRegW = memtoreg_q;
  assign bus.ReadDataW = readdata_q;
  assign bus.ALUOutW   = aluout_q;
  assign bus.WriteRegW = writereg_q;
`ifdef MISALIGN_TRAP_EN
  assign bus.MisalignW = misalign_q;
`else
  logic w_unused_misalign;
  assign w_unused_misalign = misalign_q;
`endif

endmodule : memory_stage
`default_nettype wire
